cordic_arbiter: RTL and testbench
=================================

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 Parameter BIT_WIDTH, default 16, fixed-point data width of angle and results; SHALL match the shared CORDIC engine.
REQ-002 Parameter N_REQ, default 4, number of requesters; SHALL be a power of two, 2..8.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles the arbiter waits for engine valid before aborting.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 sys_clk  input  1  single clock; all state on rising edge.
REQ-006 sys_rst_n  input  1  asynchronous active-low reset.
REQ-007 req  input  N_REQ  per-requester request level; held high until matching ack.
REQ-008 theta_in  input  N_REQ*BIT_WIDTH  packed angles; slice i = requester i, valid while req[i] high.
REQ-009 ack  output  N_REQ  one-hot, one-cycle pulse: requester's angle captured.
REQ-010 resp_valid  output  1  one-cycle pulse: result available.
REQ-011 resp_id  output  clog2(N_REQ)  requester index the result belongs to.
REQ-012 resp_sin, resp_cos  output  BIT_WIDTH each  results, held until next resp_valid.
REQ-013 resp_err  output  1  qualifies resp_valid; 1 = engine timeout, results forced to 0.
REQ-014 cor_start  output  1  one-cycle start pulse to CORDIC engine.
REQ-015 cor_theta  output  BIT_WIDTH  angle to engine.
REQ-016 cor_sin, cor_cos  input  BIT_WIDTH each  engine results.
REQ-017 cor_valid  input  1  engine one-cycle result strobe.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, GRANT, START, WAIT, RESP; all outputs registered.
REQ-020 IDLE: if any req bit high, select winner by round-robin, latch id and theta slice, -> GRANT; else stay.
REQ-021 Round-robin: search starts at pointer rr_ptr, ascending with wrap; winner is first req bit set.
REQ-022 rr_ptr SHALL update to (winner+1) mod N_REQ at each grant; no change when no grant.
REQ-023 GRANT (1 cycle): ack[id]=1, all other ack bits 0; -> START.
REQ-024 START (1 cycle): cor_start=1, cor_theta=latched angle; timer cleared; -> WAIT.
REQ-025 cor_theta SHALL stay constant from START until leaving WAIT.
REQ-026 WAIT: timer increments each cycle; on cor_valid capture cor_sin/cor_cos, resp_err<=0, -> RESP.
REQ-027 WAIT: if timer reaches TIMEOUT with no cor_valid, resp_sin/resp_cos<=0, resp_err<=1, -> RESP.
REQ-028 cor_valid and timeout in same cycle: cor_valid wins, resp_err=0.
REQ-029 RESP (1 cycle): resp_valid=1, resp_id=latched id; -> IDLE.
REQ-030 cor_valid outside WAIT SHALL be ignored, no output change.
REQ-031 req changes while not in IDLE SHALL be ignored; pending requests served after return to IDLE.
REQ-032 Latency: req sampled in IDLE at edge n -> ack at n+1, cor_start at n+2, resp_valid one cycle after the cor_valid edge.
REQ-033 Throughput: at most one outstanding engine operation; minimum 2 idle-free cycles between a resp_valid and next ack (RESP, IDLE).
REQ-034 A requester whose req drops before being granted SHALL not be granted.

Reset
REQ-035 On sys_rst_n low, immediately: state IDLE, rr_ptr 0, timer 0, ack 0, resp_valid 0, resp_err 0, resp_id 0, resp_sin/resp_cos 0, cor_start 0, cor_theta 0, busy 0.
REQ-036 Reset mid-operation SHALL abort silently: no resp_valid for the in-flight request after release.
REQ-037 First grant after reset SHALL favour requester 0 when several request.

Verification
REQ-038 Single: req=0001, theta0=0x0192; engine model returns sin=0x0100,cos=0x0000 after 20 cycles -> ack=0001 one cycle, one cor_start with cor_theta=0x0192, resp_valid with id 0, sin 0x0100, cos 0x0000, err 0.
REQ-039 Fairness: req=1111 held, each re-raised after ack -> grant order 0,1,2,3,0 and exactly one cor_start per grant.
REQ-040 Timeout: engine never asserts cor_valid -> resp_valid exactly TIMEOUT+1 cycles after cor_start, err 1, sin/cos 0, FSM back to IDLE.
REQ-041 Collision: cor_valid on same cycle timer hits TIMEOUT -> err 0, engine results forwarded.
REQ-042 Spurious: cor_valid pulsed in IDLE -> no resp_valid, resp_sin/resp_cos unchanged.
REQ-043 Reset in WAIT: assert sys_rst_n low 3 cycles -> all outputs zero immediately, no later resp_valid; next req=0100 granted normally.

Source files
------------

// File: rtl/cordic_arbiter_if.sv
// Request/response and engine-side bus of the CORDIC arbiter.
interface cordic_arbiter_if #(
    parameter int unsigned BIT_WIDTH = 16,
    parameter int unsigned N_REQ     = 4
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]           req;
    logic [N_REQ*BIT_WIDTH-1:0] theta_in;
    logic [N_REQ-1:0]           ack;
    logic                       resp_valid;
    logic [ID_W-1:0]            resp_id;
    logic [BIT_WIDTH-1:0]       resp_sin;
    logic [BIT_WIDTH-1:0]       resp_cos;
    logic                       resp_err;
    logic                       cor_start;
    logic [BIT_WIDTH-1:0]       cor_theta;
    logic [BIT_WIDTH-1:0]       cor_sin;
    logic [BIT_WIDTH-1:0]       cor_cos;
    logic                       cor_valid;
    logic                       busy;

    // Arbiter side
    modport slave (
        input  req, theta_in, cor_sin, cor_cos, cor_valid,
        output ack, resp_valid, resp_id, resp_sin, resp_cos, resp_err,
               cor_start, cor_theta, busy
    );

    // Requesters plus engine side
    modport master (
        output req, theta_in, cor_sin, cor_cos, cor_valid,
        input  ack, resp_valid, resp_id, resp_sin, resp_cos, resp_err,
               cor_start, cor_theta, busy
    );
endinterface

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one CORDIC engine among N_REQ requesters,
// with an engine-response timeout.
module cordic_arbiter #(
    parameter int unsigned BIT_WIDTH = 16,
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    cordic_arbiter_if.slave  bus
);
    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [BIT_WIDTH-1:0] theta_q, theta_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [N_REQ-1:0]     ack_q, ack_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]      resp_id_q, resp_id_d;
    logic [BIT_WIDTH-1:0] resp_sin_q, resp_sin_d;
    logic [BIT_WIDTH-1:0] resp_cos_q, resp_cos_d;
    logic                 resp_err_q, resp_err_d;
    logic                 cor_start_q, cor_start_d;
    logic [BIT_WIDTH-1:0] cor_theta_q, cor_theta_d;
    logic                 busy_q, busy_d;

    logic                 rr_found;
    logic [ID_W-1:0]      rr_win;
    logic [ID_W-1:0]      rr_idx;

    // Round-robin search: first set req bit at or after rr_ptr, with wrap
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        rr_idx   = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            rr_idx = rr_ptr_q + ID_W'(i);
            if (!rr_found && bus.req[rr_idx]) begin
                rr_found = 1'b1;
                rr_win   = rr_idx;
            end
        end
    end

    // Next-state and next-output logic; every output leaves through a register
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        theta_d      = theta_q;
        timer_d      = timer_q;
        ack_d        = '0;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_sin_d   = resp_sin_q;
        resp_cos_d   = resp_cos_q;
        resp_err_d   = resp_err_q;
        cor_start_d  = 1'b0;
        cor_theta_d  = cor_theta_q;

        case (state_q)
            S_IDLE: begin
                if (rr_found) begin
                    id_d     = rr_win;
                    theta_d  = bus.theta_in[rr_win*BIT_WIDTH +: BIT_WIDTH];
                    rr_ptr_d = rr_win + ID_W'(1);
                    state_d  = S_GRANT;
                end
            end
            S_GRANT: begin
                ack_d[id_q] = 1'b1;
                state_d     = S_START;
            end
            S_START: begin
                cor_start_d = 1'b1;
                cor_theta_d = theta_q;
                timer_d     = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the timeout cycle still counts as success
                if (bus.cor_valid) begin
                    resp_sin_d = bus.cor_sin;
                    resp_cos_d = bus.cor_cos;
                    resp_err_d = 1'b0;
                    state_d    = S_RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    resp_sin_d = '0;
                    resp_cos_d = '0;
                    resp_err_d = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_RESP: begin
                resp_valid_d = 1'b1;
                resp_id_d    = id_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            theta_q      <= '0;
            timer_q      <= '0;
            ack_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_sin_q   <= '0;
            resp_cos_q   <= '0;
            resp_err_q   <= 1'b0;
            cor_start_q  <= 1'b0;
            cor_theta_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            theta_q      <= theta_d;
            timer_q      <= timer_d;
            ack_q        <= ack_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_sin_q   <= resp_sin_d;
            resp_cos_q   <= resp_cos_d;
            resp_err_q   <= resp_err_d;
            cor_start_q  <= cor_start_d;
            cor_theta_q  <= cor_theta_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_sin   = resp_sin_q;
    assign bus.resp_cos   = resp_cos_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.cor_start  = cor_start_q;
    assign bus.cor_theta  = cor_theta_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter: requesters and engine model are
// driven on the falling edge, outputs are sampled on the falling edge.
module tb_cordic_arbiter;
    localparam int unsigned BW  = 16;
    localparam int unsigned NR  = 4;
    localparam int unsigned TO  = 255;

    typedef struct {
        int          id;
        logic [15:0] sin;
        logic [15:0] cos;
        logic        err;
        int          lat;
    } resp_t;

    logic sys_clk = 1'b0;
    logic sys_rst_n;

    always #5 sys_clk = ~sys_clk;

    cordic_arbiter_if #(.BIT_WIDTH(BW), .N_REQ(NR)) bus ();

    cordic_arbiter #(.BIT_WIDTH(BW), .N_REQ(NR), .TIMEOUT(TO)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    resp_t       exp_q[$];
    logic [3:0]  exp_ack_q[$];
    logic [15:0] theta_tab[4];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int start_cnt = 0;
    int grant_cnt = 0;
    int last_gid = 0;
    bit ack_prev = 1'b0;

    logic [3:0]  reraise = '0;
    logic [3:0]  pend = '0;

    int          eng_cnt = -1;
    int          eng_delay = 1;
    bit          eng_fixed = 1'b0;
    bit          spurious = 1'b0;
    logic [15:0] eng_sin_fix = '0;
    logic [15:0] eng_cos_fix = '0;
    logic [15:0] eng_theta = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic resp_t model_resp(input int id, input int lat);
        resp_t r;
        r.id  = id;
        r.sin = theta_tab[id] ^ 16'h5A5A;
        r.cos = ~theta_tab[id];
        r.err = 1'b0;
        r.lat = lat;
        return r;
    endfunction

    function automatic resp_t fixed_resp(input int id, input logic [15:0] s,
                                         input logic [15:0] c, input logic e, input int lat);
        resp_t r;
        r.id  = id;
        r.sin = s;
        r.cos = c;
        r.err = e;
        r.lat = lat;
        return r;
    endfunction

    // One clock: monitor outputs, then update requesters and the engine model
    task automatic step();
        resp_t      r;
        logic [3:0] ea;
        @(negedge sys_clk);
        cyc++;

        if (bus.ack !== 4'b0000) begin
            grant_cnt++;
            if (exp_ack_q.size() == 0) begin
                check("ack_unexpected", 32'(bus.ack), 32'h0);
            end else begin
                ea = exp_ack_q.pop_front();
                check("ack_onehot", 32'(bus.ack), 32'(ea));
            end
            for (int i = 0; i < int'(NR); i++)
                if (bus.ack[i]) last_gid = i;
        end
        if (bus.cor_start) begin
            start_cnt++;
            start_cyc = cyc;
            check("start_after_ack", 32'(ack_prev), 32'h1);
            check("cor_theta", 32'(bus.cor_theta), 32'(theta_tab[last_gid]));
        end
        ack_prev = (bus.ack !== 4'b0000);
        if (bus.resp_valid) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'(bus.resp_valid), 32'h0);
            end else begin
                r = exp_q.pop_front();
                check("resp_id",  32'(bus.resp_id),  32'(r.id));
                check("resp_sin", 32'(bus.resp_sin), 32'(r.sin));
                check("resp_cos", 32'(bus.resp_cos), 32'(r.cos));
                check("resp_err", 32'(bus.resp_err), 32'(r.err));
                check("resp_latency", 32'(cyc - start_cyc), 32'(r.lat));
                check("cor_theta_hold", 32'(bus.cor_theta), 32'(theta_tab[r.id]));
            end
        end

        bus.req = bus.req | pend;
        pend = '0;
        for (int i = 0; i < int'(NR); i++) begin
            if (bus.ack[i]) begin
                bus.req[i] = 1'b0;
                if (reraise[i]) begin
                    pend[i]    = 1'b1;
                    reraise[i] = 1'b0;
                end
            end
        end

        bus.cor_valid = 1'b0;
        if (spurious) begin
            bus.cor_valid = 1'b1;
            bus.cor_sin   = 16'hDEAD;
            bus.cor_cos   = 16'hBEEF;
            spurious      = 1'b0;
        end else if (bus.cor_start) begin
            eng_cnt   = eng_delay;
            eng_theta = bus.cor_theta;
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                bus.cor_valid = 1'b1;
                bus.cor_sin   = eng_fixed ? eng_sin_fix : (eng_theta ^ 16'h5A5A);
                bus.cor_cos   = eng_fixed ? eng_cos_fix : ~eng_theta;
                eng_cnt       = -1;
            end
        end
        if (!sys_rst_n) eng_cnt = -1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Run until every expected grant/response has been seen and the DUT is idle
    task automatic drain(input string tag, input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_ack_q.size() != 0 || bus.busy !== 1'b0 ||
                bus.req !== 4'b0000 || pend !== 4'b0000) && n < limit) begin
            step();
            n++;
        end
        check(tag, 32'(n < limit), 32'h1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},       32'(bus.ack),        32'h0);
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'h0);
        check({tag, "_resp_err"},  32'(bus.resp_err),   32'h0);
        check({tag, "_resp_id"},   32'(bus.resp_id),    32'h0);
        check({tag, "_resp_sin"},  32'(bus.resp_sin),   32'h0);
        check({tag, "_resp_cos"},  32'(bus.resp_cos),   32'h0);
        check({tag, "_cor_start"}, 32'(bus.cor_start),  32'h0);
        check({tag, "_cor_theta"}, 32'(bus.cor_theta),  32'h0);
        check({tag, "_busy"},      32'(bus.busy),       32'h0);
    endtask

    initial begin
        theta_tab[0] = 16'h0192;
        theta_tab[1] = 16'h1234;
        theta_tab[2] = 16'h8001;
        theta_tab[3] = 16'h7FFF;
        bus.theta_in  = {theta_tab[3], theta_tab[2], theta_tab[1], theta_tab[0]};
        bus.req       = '0;
        bus.cor_valid = 1'b0;
        bus.cor_sin   = '0;
        bus.cor_cos   = '0;
        sys_rst_n     = 1'b1;
        #2 sys_rst_n  = 1'b0;
        steps(2);
        check_all_zero("reset");
        sys_rst_n = 1'b1;
        step();

        // Fairness: all four request, each re-raised once -> 0,1,2,3,0,1,2,3
        eng_fixed = 1'b0;
        eng_delay = 3;
        for (int k = 0; k < 8; k++) begin
            exp_ack_q.push_back(4'b0001 << (k % 4));
            exp_q.push_back(model_resp(k % 4, 5));
        end
        reraise = 4'b1111;
        bus.req = 4'b1111;
        drain("drain_fair", 400);

        // Single request with a 20-cycle engine; ack two clocks after req
        eng_fixed   = 1'b1;
        eng_sin_fix = 16'h0100;
        eng_cos_fix = 16'h0000;
        eng_delay   = 20;
        exp_ack_q.push_back(4'b0001);
        exp_q.push_back(fixed_resp(0, 16'h0100, 16'h0000, 1'b0, 22));
        bus.req = 4'b0001;
        step();
        check("ack_not_early", 32'(bus.ack), 32'h0);
        check("busy_after_req", 32'(bus.busy), 32'h1);
        step();
        check("ack_latency", 32'(bus.ack), 32'h1);
        drain("drain_single", 100);

        // Spurious engine strobe in IDLE must be ignored
        spurious = 1'b1;
        steps(6);
        check("spur_sin", 32'(bus.resp_sin), 32'h0100);
        check("spur_cos", 32'(bus.resp_cos), 32'h0000);
        check("spur_busy", 32'(bus.busy), 32'h0);

        // Timeout: engine never answers
        eng_delay = -1;
        exp_ack_q.push_back(4'b1000);
        exp_q.push_back(fixed_resp(3, 16'h0000, 16'h0000, 1'b1, int'(TO) + 1));
        bus.req = 4'b1000;
        drain("drain_timeout", 600);

        // Collision: result lands on the timeout cycle
        eng_fixed   = 1'b1;
        eng_sin_fix = 16'h1111;
        eng_cos_fix = 16'h2222;
        eng_delay   = int'(TO) - 1;
        exp_ack_q.push_back(4'b0010);
        exp_q.push_back(fixed_resp(1, 16'h1111, 16'h2222, 1'b0, int'(TO) + 1));
        bus.req = 4'b0010;
        drain("drain_collide", 600);

        // Reset while waiting on the engine aborts the request silently
        eng_delay = 20;
        exp_ack_q.push_back(4'b0100);
        bus.req = 4'b0100;
        begin
            int n;
            n = 0;
            while (start_cnt != 12 && n < 50) begin
                step();
                n++;
            end
            check("rst_wait_start", 32'(start_cnt), 32'd12);
        end
        steps(5);
        sys_rst_n = 1'b0;
        #1;
        check_all_zero("rst_wait");
        bus.req = '0;
        pend    = '0;
        steps(3);
        sys_rst_n = 1'b1;
        steps(40);
        check("rst_no_resp_busy", 32'(bus.busy), 32'h0);

        // Normal grant after the aborted operation
        eng_fixed = 1'b0;
        eng_delay = 4;
        exp_ack_q.push_back(4'b0100);
        exp_q.push_back(model_resp(2, 6));
        bus.req = 4'b0100;
        drain("drain_after_rst", 100);

        check("grant_total", 32'(grant_cnt), 32'd13);
        check("start_total", 32'(start_cnt), 32'd13);
        check("queue_empty", 32'(exp_q.size() + exp_ack_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
